// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
//   parity_e   : parity mode selection (NONE / ODD / EVEN)
//   tx_state_e : transmit FSM states
//   parity_bit : parity bit for a data byte under a given mode
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  // EVEN: XOR of the data bits; ODD: inverted XOR.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    return (^data) ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, resetn : clock, synchronous active-low reset
//   push, wdata : write strobe and data (ignored while full)
//   pop         : read strobe (ignored while empty); rdata shows the head entry
//   flush       : empties the FIFO, overriding push/pop in the same cycle
//   full, empty : status from registered state
//   count       : occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Queued UART transmitter: byte FIFO in front of an 8-bit serialiser with
// optional parity and one or two stop bits.
//   clk, resetn       : clock, synchronous active-low reset
//   wr_valid, wr_data : byte offer (fire-and-forget; dropped and counted if full)
//   wr_ready          : FIFO not full
//   flush             : discard queued bytes; the frame on the line completes
//   tx                : registered serial output, idle high
//   busy              : frame in progress or FIFO non-empty
//   level             : FIFO occupancy
//   overflow_cnt      : saturating count of dropped bytes
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CLK_DIV   = 868,
  parameter parity_e     PARITY    = NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            overflow_cnt
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0] fifo_head;

  tx_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic [15:0] ovf_q;
  logic       can_start;

  // Flush wins over a same-cycle write, so the write is neither queued nor counted.
  assign fifo_push = wr_valid && !fifo_full && !flush;
  assign wr_ready  = !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (wr_data),
    .pop    (fifo_pop),
    .flush  (flush),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (level)
  );

  // A flushing cycle never starts a frame: the head being popped is being discarded.
  assign can_start = !fifo_empty && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    stop_d    = stop_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    if (state_q == IDLE) begin
      if (can_start) begin
        fifo_pop = 1'b1;
        state_d  = START;
        cnt_d    = CW'(CLK_DIV - 1);
        shreg_d  = fifo_head;
        par_d    = parity_bit(fifo_head, PARITY);
        tx_d     = 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      // Bit boundary: reload the bit timer and present the next bit.
      cnt_d = CW'(CLK_DIV - 1);
      unique case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end
        DATA: begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end else if (PARITY != NONE) begin
            state_d = PAR;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
        PAR: begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
        STOP: begin
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else if (can_start) begin
            // Back-to-back frame: no idle bit between stop and next start.
            fifo_pop = 1'b1;
            state_d  = START;
            shreg_d  = fifo_head;
            par_d    = parity_bit(fifo_head, PARITY);
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_q <= '0;
    end else if (wr_valid && fifo_full && !flush && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign tx           = tx_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign overflow_cnt = ovf_q;

endmodule
